heartbeat_gen: RTL
==================

HEARTBEAT_GEN -- requirements
Module: heartbeat_gen

Interface
REQ-001 SHALL have parameter HB_PERIOD, default 1000: cycles between heartbeat pulses, minimum 2.
REQ-002 SHALL have parameter RECOVER_CYCLES, default 16: width of subsys_reset, minimum 1.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 64: quiet time after recovery, minimum 1.
REQ-004 SHALL have parameter CNT_W, default 32: width of the internal counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1 bit: heartbeat generation permitted.
REQ-008 SHALL have port health_ok, input, 1 bit: supervised datapath alive.
REQ-009 SHALL have port force_reset, input, 1 bit: recovery request from the watchdog.
REQ-010 SHALL have port heartbeat, output, 1 bit: registered one-cycle pulse that drives the watchdog heartbeat input.
REQ-011 SHALL have port subsys_reset, output, 1 bit: registered active-high reset to the downstream datapath.
REQ-012 SHALL have port recovering, output, 1 bit: high in RECOVER or SETTLE.
REQ-013 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-014 SHALL have port recovery_count, output, 8 bits: saturating count of RECOVER entries.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN, HOLD, RECOVER and SETTLE.
REQ-016 SHALL evaluate transition priority in this order: rst, then force_reset, then enable, then health_ok.
REQ-017 SHALL move IDLE to RUN on enable=1 with health_ok=1, and IDLE to HOLD on enable=1 with health_ok=0.
REQ-018 SHALL, in RUN, increment the counter each cycle; at HB_PERIOD-1 it SHALL assert heartbeat the next cycle and clear the counter, so the first pulse occurs HB_PERIOD cycles after RUN entry.
REQ-019 SHALL clear the counter on every RUN entry.
REQ-020 SHALL never hold heartbeat high for two consecutive cycles.
REQ-021 SHALL move RUN to HOLD on health_ok=0, freeze the counter, and emit no heartbeat in HOLD.
REQ-022 SHALL move HOLD to RUN on health_ok=1.
REQ-023 SHALL move RUN, HOLD or SETTLE to IDLE on enable=0 and clear the counter.
REQ-024 SHALL move IDLE, RUN, HOLD or SETTLE to RECOVER when force_reset=1 is sampled.
REQ-025 SHALL assert subsys_reset for exactly RECOVER_CYCLES cycles, beginning the cycle after RECOVER entry.
REQ-026 SHALL ignore force_reset and enable while in RECOVER, and RECOVER SHALL always run to completion.
REQ-027 SHALL move RECOVER to SETTLE; after SETTLE_CYCLES cycles SETTLE SHALL go to RUN if enable=1, else to IDLE.
REQ-028 SHALL emit no heartbeat in IDLE, HOLD, RECOVER or SETTLE.
REQ-029 SHALL keep recovering combinationally consistent with state in the same cycle.
REQ-030 SHALL compare the counter without overflow; HB_PERIOD SHALL be less than 2^CNT_W, with an elaboration check.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, force IDLE and drive heartbeat=0, subsys_reset=0, recovering=0, recovery_count=0 and counter=0.
REQ-032 SHALL apply rst mid-RECOVER immediately, deasserting subsys_reset on the next cycle.

Configuration
REQ-033 SHALL, with HB_RECOVERY_LOG_EN defined, increment recovery_count on each RECOVER entry and saturate it at 255.
REQ-034 SHALL, without HB_RECOVERY_LOG_EN, tie recovery_count to 0 and synthesise no counter logic for it.

Structure
REQ-035 SHALL place the state enum (3-bit) and the default values of HB_PERIOD, RECOVER_CYCLES and SETTLE_CYCLES in a shared package heartbeat_pkg.
REQ-036 SHALL use one sub-module, hb_cycle_timer: a loadable down-counter with a done flag, shared by RECOVER and SETTLE timing.

Verification
All scenarios use HB_PERIOD=8, RECOVER_CYCLES=4, SETTLE_CYCLES=6 and HB_RECOVERY_LOG_EN defined.
REQ-037 SHALL cover: rst released, enable=1, health_ok=1 -> heartbeat pulses 8, 16 and 24 cycles after RUN entry, each exactly 1 cycle wide.
REQ-038 SHALL cover: health_ok=0 for 10 cycles starting at period count 5 -> no pulse during HOLD, next pulse 8 cycles after HOLD exit.
REQ-039 SHALL cover: a 1-cycle force_reset in RUN -> subsys_reset high exactly 4 cycles, recovering high 10 cycles, next heartbeat 8 cycles after RUN re-entry, recovery_count=1.
REQ-040 SHALL cover: force_reset re-asserted during RECOVER, plus enable=0 -> subsys_reset still exactly 4 cycles, recovery_count=1, IDLE reached 1 cycle after SETTLE entry.
REQ-041 SHALL cover: rst asserted on the 2nd subsys_reset cycle -> all outputs 0 on the next cycle, state=IDLE.
REQ-042 SHALL cover: 300 forced recoveries -> recovery_count holds at 255; the same run without HB_RECOVERY_LOG_EN -> recovery_count stays 0.

Source files
------------

// File: rtl/heartbeat_pkg.sv
// Shared types and default timing for the heartbeat generator and its recovery timer.
package heartbeat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_SETTLE  = 3'd4
  } hb_state_e;

  localparam int unsigned HB_PERIOD_DEF      = 1000;
  localparam int unsigned RECOVER_CYCLES_DEF = 16;
  localparam int unsigned SETTLE_CYCLES_DEF  = 64;
  localparam int unsigned TMR_W              = 16;

  function automatic logic is_recovering(input hb_state_e s);
    return (s == ST_RECOVER) || (s == ST_SETTLE);
  endfunction

endpackage

// File: rtl/hb_cycle_timer.sv
// Loadable down-counter with a terminal-count flag; times both RECOVER and SETTLE.
module hb_cycle_timer
  import heartbeat_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/heartbeat_gen.sv
// Heartbeat pulse generator with watchdog-driven subsystem recovery.
// Optional saturating recovery log enabled by defining HB_RECOVERY_LOG_EN.
//
// state   | meaning
// IDLE    | generation disabled, counter cleared
// RUN     | counting, one-cycle heartbeat every HB_PERIOD cycles
// HOLD    | datapath unhealthy, counter frozen, no heartbeat
// RECOVER | subsys_reset pulse in progress, inputs ignored
// SETTLE  | quiet time after recovery before resuming
module heartbeat_gen
  import heartbeat_pkg::*;
#(
  parameter int unsigned HB_PERIOD      = HB_PERIOD_DEF,
  parameter int unsigned RECOVER_CYCLES = RECOVER_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       health_ok,
  input  logic       force_reset,
  output logic       heartbeat,
  output logic       subsys_reset,
  output logic       recovering,
  output logic [2:0] state,
  output logic [7:0] recovery_count
);

  if (HB_PERIOD < 2) begin : g_bad_period_min
    $error("heartbeat_gen: HB_PERIOD must be at least 2");
  end
  if (CNT_W < 64 && 64'(HB_PERIOD) >= (64'd1 << CNT_W)) begin : g_bad_period_width
    $error("heartbeat_gen: HB_PERIOD does not fit in CNT_W bits");
  end
  if (RECOVER_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_timer_min
    $error("heartbeat_gen: RECOVER_CYCLES and SETTLE_CYCLES must be at least 1");
  end
  if (64'(RECOVER_CYCLES) > (64'd1 << TMR_W) || 64'(SETTLE_CYCLES) > (64'd1 << TMR_W)) begin : g_bad_timer_width
    $error("heartbeat_gen: recovery timing exceeds timer width");
  end

  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HB_PERIOD - 1);
  localparam logic [TMR_W-1:0] REC_LOAD = TMR_W'(RECOVER_CYCLES - 1);
  localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  hb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hb_d;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;
  logic             rec_entry;

  hb_cycle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (force_reset)  state_d = ST_RECOVER;
        else if (enable)  state_d = health_ok ? ST_RUN : ST_HOLD;
      end
      ST_RUN: begin
        if (force_reset)     state_d = ST_RECOVER;
        else if (!enable)    state_d = ST_IDLE;
        else if (!health_ok) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (force_reset)    state_d = ST_RECOVER;
        else if (!enable)   state_d = ST_IDLE;
        else if (health_ok) state_d = ST_RUN;
      end
      ST_RECOVER: begin
        if (tmr_done) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (force_reset)   state_d = ST_RECOVER;
        else if (!enable)  state_d = ST_IDLE;
        else if (tmr_done) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulse only when staying in RUN so a leaving transition can never emit one.
  always_comb begin
    cnt_d = cnt_q;
    hb_d  = 1'b0;
    if (state_d == ST_RUN) begin
      if (state_q != ST_RUN) begin
        cnt_d = '0;
      end else if (cnt_q == HB_LAST) begin
        cnt_d = '0;
        hb_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end
  end

  assign rec_entry = (state_d == ST_RECOVER) && (state_q != ST_RECOVER);
  assign tmr_load  = (state_d != state_q) && ((state_d == ST_RECOVER) || (state_d == ST_SETTLE));
  assign tmr_val   = (state_d == ST_RECOVER) ? REC_LOAD : SET_LOAD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      heartbeat    <= 1'b0;
      subsys_reset <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      heartbeat    <= hb_d;
      subsys_reset <= (state_q == ST_RECOVER);
    end
  end

  assign recovering = is_recovering(state_q);
  assign state      = state_q;

`ifdef HB_RECOVERY_LOG_EN
  logic [7:0] rec_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_cnt_q <= '0;
    end else if (rec_entry && (rec_cnt_q != 8'hFF)) begin
      rec_cnt_q <= rec_cnt_q + 1'b1;
    end
  end

  assign recovery_count = rec_cnt_q;
`else
  logic unused_rec_entry;
  assign unused_rec_entry = rec_entry;
  assign recovery_count   = '0;
`endif

endmodule
